fb_write_arbiter: RTL and testbench
===================================

# fb_write_arbiter

Shares the single write port of `frame_buffer` among `NUM_REQ` pixel writers (frame renderer, frame buffer test pattern, future sprite writers) using a valid/ready handshake and round-robin arbitration. It also sequences frames: once every enabled writer has delivered its last pixel, all writers are stalled until the frame buffer `swap` pulse arrives. The block sits in the renderer clock domain, between the writers and the `frame_buffer` write interface, and replaces the switch-driven combinational write mux.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `ADDR_WIDTH`, 19: pixel address width (`$clog2(640*480)`).
- `clk`  in  1  renderer clock; the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `ce`  in  1  clock enable (PLL lock); when low, all state holds.
- `enable_mask`  in  NUM_REQ  requester enable; latched only at frame boundaries.
- `req_valid`  in  NUM_REQ  requester i presents a pixel.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  pixel address; slice i = `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_data`  in  NUM_REQ  pixel value (1 bpp).
- `req_last`  in  NUM_REQ  marks the requester's final pixel of the frame.
- `req_ready`  out  NUM_REQ  one-hot grant; a beat transfers when `req_valid[i] & req_ready[i]`.
- `swap`  in  1  single-cycle pulse, already synchronised to `clk`, signalling that the buffers have swapped.
- `wr_en`  out  1  frame buffer write enable.
- `wr_addr`  out  ADDR_WIDTH  frame buffer write address.
- `wr_data`  out  1  frame buffer write data.
- `frame_pending`  out  1  high in `WAIT_SWAP`.
- `overrun_count`  out  8  saturating count of swaps that arrived before the frame completed.

## Operation
- Reset values: `state=ARBITRATE`, `mask_q=0`, `done=0`, `rr_ptr=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `overrun_count=0`. `req_ready=0` and `frame_pending=0` while reset is asserted.
- On the first `ce` cycle after reset, `mask_q` loads `enable_mask`. The state goes to `WAIT_SWAP` if the latched mask is all zeros.
- Eligible set: `req_valid & mask_q & ~done`.
- `ARBITRATE` state:
  - Grant the first eligible index at or after `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `req_ready` is one-hot on that index, or zero if no index is eligible.
  - On a transfer, set `rr_ptr` to the granted index + 1 (mod `NUM_REQ`).
  - On a transfer with `req_last` high, set `done[i]`.
  - When `(done | transfer_last) & mask_q == mask_q`, go to `WAIT_SWAP`.
- `WAIT_SWAP` state:
  - `req_ready=0` and `frame_pending=1`.
  - On `swap`: clear `done`, reload `mask_q` from `enable_mask`, and go to `ARBITRATE`. If the new mask is all zeros, stay in `WAIT_SWAP`.
- A `swap` that arrives while in `ARBITRATE` increments `overrun_count`, saturating at 255. It does not change state or `done`.
- A `swap` in the same cycle as the frame-completing transfer counts as an overrun, and the block still enters `WAIT_SWAP`. The next `swap` releases it.
- Requesters that are masked, or whose `done` is set, never see `req_ready` high.
- A change to `enable_mask` in mid-frame has no effect until the next swap.

## Timing
- `req_ready` is combinational from registered state and `req_valid`. It has no path from `swap`.
- Write latency: a transfer in cycle n produces `wr_en=1` with that beat's `wr_addr`/`wr_data` in cycle n+1.
- Sustained throughput is 1 write per cycle. With k requesters continuously valid, each receives every k-th cycle.
- `wr_en` is 0 in any cycle that follows a cycle without a transfer. `wr_addr`/`wr_data` hold their last values.
- `ce=0`: no transfer occurs (`req_ready=0`), `wr_en=0`, and all registers hold. A `swap` pulse during `ce=0` is lost.
- Asserting `rst_n` in mid-frame aborts the frame immediately: `wr_en` drops asynchronously, and any in-flight beat is discarded.
- The transition into `WAIT_SWAP` happens at the clock edge of the last transfer. `req_ready` is 0 from the next cycle.

## Test plan
- Single requester: `enable_mask=01`, req0 valid on every cycle, addr 0..3 with `last` on addr 3. Required: `wr_en` high for 4 cycles carrying addr 0,1,2,3, delayed by one cycle; then `frame_pending=1` and `req_ready=00` until `swap`; 1 cycle after `swap`, `req_ready[0]=1`.
- Round-robin fairness: `mask=11`, both requesters valid on every cycle for 8 cycles. Required: grants alternate 0,1,0,1…; each requester gets 4 writes; the `wr_addr` sequence interleaves the two address streams.
- Uneven finish: req0 sends `last` at beat 2, req1 at beat 6. Required: after req0's `last`, all grants go to req1 (`req_ready[0]=0`); `WAIT_SWAP` is entered only after req1's `last`.
- Overrun: `swap` pulses while req1 is still unfinished, then again in the cycle of req1's `last`. Required: `overrun_count=2`, state `WAIT_SWAP`; a third `swap` releases the block with `overrun_count` still 2.
- Mask and `ce`: in mid-frame change `enable_mask` to `10` and hold `ce=0` for 3 cycles. Required: the old mask still governs the current frame; no writes occur during the `ce` gap; after `swap`, only req1 is granted.
- Reset mid-frame: drive `rst_n` low between clock edges during active writes. Required: `wr_en=0` and `req_ready=0` immediately; after release, `done=0`, `overrun_count=0`, and arbitration restarts at index 0.

Source files
------------

// File: rtl/fb_write_arbiter_if.sv
// Pixel-writer side of the frame buffer write arbiter: one valid/ready lane per requester.
interface fb_write_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 19
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0]            req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;

  modport master (
    output req_valid, req_addr, req_data, req_last,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_last,
    output req_ready
  );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the frame buffer write port among NUM_REQ pixel writers,
// stalling all writers between a completed frame and the next buffer swap.
module fb_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic [NUM_REQ-1:0]    enable_mask,
  input  logic                  swap,
  fb_write_arbiter_if.slave     req_bus,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_data,
  output logic                  frame_pending,
  output logic [7:0]            overrun_count
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ARBITRATE = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic                  loaded_r;
  logic [NUM_REQ-1:0]    mask_r;
  logic [NUM_REQ-1:0]    done_r;
  logic [PTR_W-1:0]      rr_ptr_r;
  logic [7:0]            overrun_r;
  logic                  wr_en_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic                  wr_data_r;

  logic                  arb_active_s;
  logic [NUM_REQ-1:0]    eligible_s;
  logic                  hi_found_s;
  logic                  lo_found_s;
  logic [PTR_W-1:0]      hi_idx_s;
  logic [PTR_W-1:0]      lo_idx_s;
  logic                  found_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic [PTR_W-1:0]      rr_next_s;
  logic [NUM_REQ-1:0]    grant_s;
  logic [NUM_REQ-1:0]    last_hit_s;
  logic                  xfer_s;
  logic                  frame_done_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic                  sel_data_s;

  // Nothing is granted until the mask has been latched once after reset.
  assign arb_active_s = ce & loaded_r & (state_r == ARBITRATE);
  assign eligible_s   = req_bus.req_valid & mask_r & ~done_r;

  // Round-robin search: lowest eligible index at/after rr_ptr, else lowest eligible overall.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = '0;
    lo_idx_s   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      lo_found_s = lo_found_s | eligible_s[i];
      lo_idx_s   = eligible_s[i] ? PTR_W'(i) : lo_idx_s;
      hi_found_s = hi_found_s | (eligible_s[i] & (i >= int'(rr_ptr_r)));
      hi_idx_s   = (eligible_s[i] && (i >= int'(rr_ptr_r))) ? PTR_W'(i) : hi_idx_s;
    end
    found_s     = hi_found_s | lo_found_s;
    grant_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // One-hot grant plus the beat it selects.
  always_comb begin
    grant_s    = '0;
    sel_addr_s = '0;
    sel_data_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_s[i] = arb_active_s & found_s & (grant_idx_s == PTR_W'(i));
      sel_addr_s = grant_s[i] ? req_bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] : sel_addr_s;
      sel_data_s = grant_s[i] ? req_bus.req_data[i] : sel_data_s;
    end
  end

  assign xfer_s       = |grant_s;
  assign last_hit_s   = grant_s & req_bus.req_last;
  assign frame_done_s = (((done_r | last_hit_s) & mask_r) == mask_r);
  assign rr_next_s    = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : (grant_idx_s + PTR_W'(1));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARBITRATE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; an all-zero mask parks the block in WAIT_SWAP.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ARBITRATE: begin
        if (!ce) begin
          state_next_s = ARBITRATE;
        end else if (!loaded_r) begin
          state_next_s = (enable_mask == '0) ? WAIT_SWAP : ARBITRATE;
        end else if (frame_done_s) begin
          state_next_s = WAIT_SWAP;
        end else begin
          state_next_s = ARBITRATE;
        end
      end
      WAIT_SWAP: begin
        if (ce && swap) begin
          state_next_s = (enable_mask == '0) ? WAIT_SWAP : ARBITRATE;
        end else begin
          state_next_s = WAIT_SWAP;
        end
      end
      default: state_next_s = ARBITRATE;
    endcase
  end

  // FSM outputs: grant is combinational from registered state and req_valid only.
  always_comb begin
    req_bus.req_ready = grant_s;
    frame_pending     = (state_r == WAIT_SWAP);
  end

  // Frame bookkeeping: mask latch, per-requester done flags, round-robin pointer, overruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_r  <= 1'b0;
      mask_r    <= '0;
      done_r    <= '0;
      rr_ptr_r  <= '0;
      overrun_r <= 8'd0;
    end else if (ce) begin
      if (!loaded_r) begin
        loaded_r <= 1'b1;
        mask_r   <= enable_mask;
      end else if (state_r == WAIT_SWAP) begin
        if (swap) begin
          done_r <= '0;
          mask_r <= enable_mask;
        end
      end else begin
        done_r <= done_r | last_hit_s;
        if (xfer_s) begin
          rr_ptr_r <= rr_next_s;
        end
        if (swap && (overrun_r != 8'hFF)) begin
          overrun_r <= overrun_r + 8'd1;
        end
      end
    end
  end

  // Write port register: one-cycle latency; wr_en clears on any edge without a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= 1'b0;
    end else begin
      wr_en_r <= xfer_s;
      if (xfer_s) begin
        wr_addr_r <= sel_addr_s;
        wr_data_r <= sel_data_s;
      end
    end
  end

  assign wr_en         = wr_en_r;
  assign wr_addr       = wr_addr_r;
  assign wr_data       = wr_data_r;
  assign overrun_count = overrun_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Table-driven bench for fb_write_arbiter with a write-port scoreboard.
module tb_fb_write_arbiter;

  localparam int NR = 2;
  localparam int AW = 19;

  logic          clk;
  logic          rst_n;
  logic          ce;
  logic [NR-1:0] enable_mask;
  logic          swap;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          frame_pending;
  logic [7:0]    overrun_count;

  fb_write_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) bus ();

  fb_write_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ce            (ce),
    .enable_mask   (enable_mask),
    .swap          (swap),
    .req_bus       (bus),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_pending (frame_pending),
    .overrun_count (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] mask;
    logic [1:0] valid;
    logic [1:0] last;
    logic       ce;
    logic       swap;
    logic [1:0] rdy;
    logic       pend;
    logic [7:0] ovr;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          data;
  } beat_t;

  vec_t  vt [46];
  beat_t sb_q [$];
  int    n_tests;
  int    n_fail;

  function automatic vec_t v(input logic [1:0] mask, input logic [1:0] valid,
                             input logic [1:0] last, input logic c, input logic s,
                             input logic [1:0] rdy, input logic pend, input logic [7:0] ovr);
    vec_t t;
    t.mask = mask; t.valid = valid; t.last = last; t.ce = c; t.swap = s;
    t.rdy = rdy; t.pend = pend; t.ovr = ovr;
    return t;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int i, input int r);
    return AW'(i * 4096 + r);
  endfunction

  function automatic logic data_of(input int i, input int r);
    logic [31:0] rv;
    rv = 32'(r + i);
    return rv[0];
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got 0x%0h, expected 0x%0h", name, row, got, exp);
    end
  endtask

  task automatic run_row(input int r);
    vec_t  t;
    beat_t b;
    logic  exp_we;
    t = vt[r];
    enable_mask   = t.mask;
    bus.req_valid = t.valid;
    bus.req_last  = t.last;
    ce            = t.ce;
    swap          = t.swap;
    bus.req_addr  = {addr_of(1, r), addr_of(0, r)};
    bus.req_data  = {data_of(1, r), data_of(0, r)};
    #3;
    chk("req_ready", r, 32'(bus.req_ready), 32'(t.rdy));
    chk("frame_pending", r, 32'(frame_pending), 32'(t.pend));
    chk("overrun_count", r, 32'(overrun_count), 32'(t.ovr));
    exp_we = |(t.rdy & t.valid);
    for (int i = 0; i < NR; i++) begin
      if (t.rdy[i] && t.valid[i]) begin
        b.addr = addr_of(i, r);
        b.data = data_of(i, r);
        sb_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    swap = 1'b0;
    chk("wr_en", r, 32'(wr_en), 32'(exp_we));
    if (wr_en && sb_q.size() > 0) begin
      b = sb_q.pop_front();
      chk("wr_addr", r, 32'(wr_addr), 32'(b.addr));
      chk("wr_data", r, 32'(wr_data), 32'(b.data));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // single requester, addr stream with last on the 4th beat, then swap release
    vt[0]  = v(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    vt[1]  = v(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    vt[2]  = v(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    vt[3]  = v(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    vt[4]  = v(2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    vt[5]  = v(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'd0);
    vt[6]  = v(2'b01, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'd0);
    vt[7]  = v(2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 8'd0);
    vt[8]  = v(2'b01, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    vt[9]  = v(2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 8'd0);
    // round robin: pointer sits at 1 after req0's beats
    for (int k = 0; k < 8; k++)
      vt[10+k] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, (k % 2 == 0) ? 2'b10 : 2'b01, 1'b0, 8'd0);
    // uneven finish
    vt[18] = v(2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 2'b10, 1'b0, 8'd0);
    vt[19] = v(2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    vt[20] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 8'd0);
    vt[21] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 8'd0);
    vt[22] = v(2'b11, 2'b11, 2'b10, 1'b1, 1'b0, 2'b10, 1'b0, 8'd0);
    vt[23] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'd0);
    // overrun: early swap, then swap with the frame-completing beat
    vt[24] = v(2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 8'd0);
    vt[25] = v(2'b11, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    vt[26] = v(2'b11, 2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0, 8'd0);
    vt[27] = v(2'b11, 2'b10, 2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 8'd1);
    vt[28] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 8'd2);
    vt[29] = v(2'b11, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 8'd2);
    // mid-frame mask change and ce gap with a lost swap
    vt[30] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 8'd2);
    vt[31] = v(2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'd2);
    vt[32] = v(2'b10, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd2);
    vt[33] = v(2'b10, 2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 8'd2);
    vt[34] = v(2'b10, 2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 8'd2);
    vt[35] = v(2'b10, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 8'd2);
    vt[36] = v(2'b10, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 8'd2);
    vt[37] = v(2'b10, 2'b11, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 8'd2);
    vt[38] = v(2'b10, 2'b11, 2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 8'd2);
    vt[39] = v(2'b10, 2'b11, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1, 8'd2);
    vt[40] = v(2'b10, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 8'd2);
    vt[41] = v(2'b10, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 8'd2);
    vt[42] = v(2'b10, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 8'd2);
    // after a mid-frame reset: reload cycle, then arbitration from index 0
    vt[43] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0);
    vt[44] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 8'd0);
    vt[45] = v(2'b11, 2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0, 8'd0);

    rst_n         = 1'b0;
    ce            = 1'b1;
    enable_mask   = 2'b01;
    swap          = 1'b0;
    bus.req_valid = 2'b01;
    bus.req_last  = 2'b00;
    bus.req_addr  = '0;
    bus.req_data  = 2'b00;

    #12;
    chk("rst_req_ready", -1, 32'(bus.req_ready), 32'd0);
    chk("rst_frame_pending", -1, 32'(frame_pending), 32'd0);
    chk("rst_wr_en", -1, 32'(wr_en), 32'd0);
    chk("rst_wr_addr", -1, 32'(wr_addr), 32'd0);
    chk("rst_overrun", -1, 32'(overrun_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int r = 0; r <= 42; r++) run_row(r);

    // mid-frame reset between edges while a write is on the port
    chk("pre_reset_wr_en", 42, 32'(wr_en), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_wr_en", 42, 32'(wr_en), 32'd0);
    chk("async_req_ready", 42, 32'(bus.req_ready), 32'd0);
    chk("async_overrun", 42, 32'(overrun_count), 32'd0);
    chk("async_pending", 42, 32'(frame_pending), 32'd0);
    @(posedge clk);
    #1;
    chk("held_wr_en", 42, 32'(wr_en), 32'd0);
    rst_n = 1'b1;

    for (int r = 43; r <= 45; r++) run_row(r);

    chk("scoreboard_empty", 45, 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
